// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: COLS_PER_CYCLE columns per clock over a shared GF(2^8) datapath.
// Optional macro AES_MC_BYPASS_EN adds bypass_in to pass columns through unchanged (final round).
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
`ifdef AES_MC_BYPASS_EN
    input  logic         bypass_in,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    // state | meaning
    // IDLE  | waiting for a state, in_ready high
    // CALC  | computing COLS_PER_CYCLE columns per edge
    // DONE  | result held, out_valid high until out_ready

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int         NCYC     = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST_COL = 2'(COLS_PER_CYCLE * (NCYC - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [127:0]  data_q;
    logic [127:0]  result_q;
    logic [1:0]    col_cnt;
    logic          accept;
    logic          last_step;
    logic [1:0]    col_idx [COLS_PER_CYCLE];
    logic [31:0]   col_src [COLS_PER_CYCLE];
    logic [31:0]   col_res [COLS_PER_CYCLE];
`ifdef AES_MC_BYPASS_EN
    logic          bypass_q;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

    assign accept    = in_valid && in_ready;
    assign last_step = (col_cnt == LAST_COL);
    assign state_out = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == CALC) || (state == DONE);
    end

    // Column c lives at bits [127-32c -: 32]; row 0 is the top byte.
    always_comb begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            col_idx[j] = col_cnt + 2'(j);
            col_src[j] = data_q[32*(3 - int'(col_idx[j])) +: 32];
`ifdef AES_MC_BYPASS_EN
            col_res[j] = bypass_q ? col_src[j] : mix_col(col_src[j]);
`else
            col_res[j] = mix_col(col_src[j]);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= 128'h0;
            result_q <= 128'h0;
            col_cnt  <= 2'd0;
`ifdef AES_MC_BYPASS_EN
            bypass_q <= 1'b0;
`endif
        end else if (accept) begin
            data_q  <= state_in;
            col_cnt <= 2'd0;
`ifdef AES_MC_BYPASS_EN
            bypass_q <= bypass_in;
`endif
        end else if (state == CALC) begin
            for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                result_q[32*(3 - int'(col_idx[j])) +: 32] <= col_res[j];
            end
            col_cnt <= col_cnt + STEP;
        end
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Iterative AES MixColumns stage. Sits directly downstream of shift_rows in the encryption round datapath and consumes its 128-bit output.
- Processes COLS_PER_CYCLE columns per clock over a shared GF(2^8) datapath.
- Uses valid/ready handshakes on both sides, so it can be stalled by the AddRoundKey/round-register stage it feeds.
- Byte layout matches shift_rows: column c occupies state[127-32c -: 32]; row 0 is the MS byte of each column.

Parameters:
- COLS_PER_CYCLE, 1, columns computed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error. NCYC = 4/COLS_PER_CYCLE.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  block can accept a state
- state_in  input  128  state from shift_rows
- out_valid  output  1  state_out is valid
- out_ready  input  1  downstream accepts state_out
- state_out  output  128  MixColumns result, registered
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset is asynchronous, active-low; one clock (clk).
- Reset values: FSM=IDLE, col_cnt=0, in_ready=1, out_valid=0, busy=0, state_out=128'h0, captured-state register=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge: capture state_in, col_cnt<=0, go to CALC.
  - CALC: in_ready=0. Each edge computes columns col_cnt..col_cnt+COLS_PER_CYCLE-1 into the result register; col_cnt += COLS_PER_CYCLE. On the edge that writes column 3: out_valid<=1, go to DONE.
  - DONE: out_valid=1; state_out is held stable. On out_ready at an edge: out_valid<=0, go to IDLE.
- No acceptance in DONE: in_ready=0 even when out_ready=1. The next state is accepted one cycle after the output handshake.
- Latency: accept at edge k; out_valid rises after edge k+NCYC (4, 2 or 1).
- Throughput: at most one state per NCYC+2 cycles.
- state_out updates only in CALC. Unused result columns are not cleared between blocks, and the full 128 bits are overwritten before out_valid rises.
- Column arithmetic, with a0..a3 = rows 0..3 of the column:
  - r0=2a0^3a1^a2^a3
  - r1=a0^2a1^3a2^a3
  - r2=a0^a1^2a2^3a3
  - r3=3a0^a1^a2^2a3
  - 2x = xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1b : 0); 3x = xtime(x)^x. All widths are 8-bit with no carries.
- in_valid while in_ready=0 is ignored; upstream must hold it.
- out_ready while out_valid=0 is ignored.
- Reset mid-CALC or mid-DONE: the in-flight state is discarded, all outputs return to reset values immediately, and no partial output is ever flagged valid.

Optional Feature:
- Macro AES_MC_BYPASS_EN.
- Defined:
  - Adds port bypass_in (input, 1), sampled on the input handshake and stored with the state.
  - When the stored bit is 1 (AES final round), each column result equals the input column unchanged.
  - Latency, FSM and handshakes are identical to the non-bypass case, so round timing stays uniform.
- Undefined: the port does not exist and MixColumns is always applied.

Test Plan:
- FIPS-197 App. B round 1, COLS_PER_CYCLE=1, out_ready=1: state_in=d4bf5d30e0b452aeb84111f11e2798e5 -> state_out=046681e5e0cb199a48f8d37a2806264c, out_valid high exactly 4 edges after accept, in_ready low 5 cycles.
- Single-column vectors in column 0, other columns 0: db135345->8e4da1bc, f20a225c->9fdc589d, c6c6c6c6->c6c6c6c6, d4d4d4d5->d5d5d7d6, 2d26314c->4d7ebdf8; zero columns stay 0. Repeat for COLS_PER_CYCLE=2 (latency 2) and 4 (latency 1).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> state_out stable, in_ready=0, in_valid ignored. Release -> out_valid drops next edge, in_ready=1 the cycle after.
- Reset mid-CALC: assert rst_n=0 after 2 CALC edges -> out_valid=0, state_out=0, in_ready=1 asynchronously. Next accepted state yields a correct result.
- Back-to-back stream of 8 random states with random out_ready -> every output matches the reference model in order, with no drops or duplicates.
- With AES_MC_BYPASS_EN, bypass_in=1, state_in=d4bf5d30e0b452aeb84111f11e2798e5 -> state_out identical to input at the same latency. With bypass_in=0, the output matches the round-1 vector.
